// File: rtl/apu_timer_bank.sv
// Multi-channel programmable down-counter/divider with one-shot or looping periods.
// Optional shared prescaler enabled by defining APU_TIMER_PRESCALE_EN.
module apu_timer_bank #(
  parameter int unsigned NCH = 4,
  parameter int unsigned N   = 11,
  parameter int unsigned PW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   en,
  input  logic [NCH-1:0]   reload,
  input  logic [NCH-1:0]   loop,
  input  logic [NCH*N-1:0] load,
`ifdef APU_TIMER_PRESCALE_EN
  input  logic [PW-1:0]    psc_div,
`endif
  output logic [NCH-1:0]   tick,
  output logic [NCH*N-1:0] cnt,
  output logic [NCH-1:0]   active
);

  logic step;

`ifdef APU_TIMER_PRESCALE_EN
  logic [PW-1:0] psc;

  // Free-running shared prescaler; psc_div is only picked up when psc wraps.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psc <= '0;
    end else if (psc == '0) begin
      psc <= psc_div;
    end else begin
      psc <= psc - 1'b1;
    end
  end

  assign step = (psc == '0);
`else
  // PW has no role without the prescaler.
  logic [PW-1:0] unused_psc;
  assign unused_psc = '0;
  assign step       = 1'b1;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [N-1:0] ld;
    logic [N-1:0] cnt_q;
    logic         tick_q;
    logic         active_q;

    assign ld = load[i*N +: N];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q    <= '0;
        tick_q   <= 1'b0;
        active_q <= 1'b0;
      end else if (reload[i]) begin
        // Reload outranks any same-cycle expiry or decrement.
        cnt_q    <= ld;
        active_q <= 1'b1;
        tick_q   <= 1'b0;
      end else if (en[i] && step && active_q) begin
        if (cnt_q == '0) begin
          tick_q <= 1'b1;
          if (loop[i]) begin
            cnt_q <= ld;
          end else begin
            active_q <= 1'b0;
          end
        end else begin
          cnt_q  <= cnt_q - 1'b1;
          tick_q <= 1'b0;
        end
      end else begin
        tick_q <= 1'b0;
      end
    end

    assign cnt[i*N +: N] = cnt_q;
    assign tick[i]       = tick_q;
    assign active[i]     = active_q;
  end

endmodule
